mcause_trap_capture: RTL and testbench
======================================

Name: mcause_trap_capture

Overview:
- Producer stage for the machine trap-cause state consumed by the MCause trace/insight view.
- Captures the CLIC-format mcause on trap entry, tracks the hardware-vectoring table fetch (minhv), services mret restore and CSR-mapped reads/writes.
- Drives the unpacked field outputs that the insight view mirrors.
- Sits between the core trap/commit logic and the CSR file.

Parameters:
- CODE_W, 10, width of exception/interrupt code field (mcause[CODE_W-1:0])
- IL_W, 8, interrupt-level width (mpil, mcause[23:16])
- U_MODE, 1, 1 = U-mode implemented (mpp may hold 0), 0 = mpp hardwired to 3

Ports:
- clock  in  1  core clock
- reset  in  1  synchronous, active-high reset
- trap_valid  in  1  trap taken this cycle (single-cycle pulse)
- trap_irq  in  1  trap is an interrupt
- trap_code  in  CODE_W  cause code
- trap_shv  in  1  selective hardware vectoring applies (interrupt only)
- cur_priv  in  2  privilege at trap time
- cur_mie  in  1  mstatus.MIE at trap time
- cur_il  in  IL_W  current interrupt level (mintstatus.mil)
- vec_fetch_done  in  1  vector-table load completed without fault
- mret_valid  in  1  mret retiring
- csr_wen  in  1  mcause CSR write
- csr_wdata  in  32  write data
- csr_rdata  out  32  packed mcause
- ret_valid  out  1  restore strobe, one cycle after mret_valid
- ret_priv  out  2  privilege to restore
- ret_mie  out  1  MIE to restore
- ret_il  out  IL_W  level to restore
- code  out  CODE_W  field
- mpil  out  IL_W  field
- mpie  out  1  field
- mpp  out  2  field
- minhv  out  1  field
- mcause_interrupt  out  1  field
- vec_busy  out  1  high while in VEC_FETCH

Behaviour:
- Packing: bit31 interrupt, bit30 minhv, 29:28 mpp, bit27 mpie, 26:24 zero, 23:16 mpil, 15:CODE_W zero, CODE_W-1:0 code. Reserved bits read 0 and ignore writes. csr_rdata is combinational from the registers.
- Reset values: all fields 0, except mpp = 3 when U_MODE = 0. ret_valid = 0, ret_* = 0, vec_busy = 0, FSM in IDLE.
- Trap capture, effective the next edge:
  - code <= trap_code; interrupt <= trap_irq; mpp <= cur_priv; mpie <= cur_mie; mpil <= cur_il.
  - If trap_irq and trap_shv: minhv <= 1 and FSM goes IDLE -> VEC_FETCH. Otherwise minhv <= 0.
- FSM:
  - IDLE -> VEC_FETCH on a vectored trap.
  - VEC_FETCH -> IDLE on vec_fetch_done; minhv <= 0 on that same edge.
  - trap_valid while in VEC_FETCH is a fetch fault. Recapture code/interrupt/mpp/mpie/mpil, but minhv stays 1 (unless the new trap is itself vectored; it is then still 1). FSM goes to VEC_FETCH only if the new trap is vectored, otherwise IDLE.
  - vec_fetch_done in IDLE is ignored.
- mret:
  - ret_valid is registered 1 cycle later. ret_priv = mpp, ret_mie = mpie, ret_il = mpil, all sampled at mret_valid.
  - Then, on the same edge that drives ret_valid: mpp <= (U_MODE ? 0 : 3); mpie <= 1.
  - mret in VEC_FETCH aborts the fetch: FSM -> IDLE, minhv <= 0.
- CSR write (WARL):
  - All non-reserved fields written.
  - mpp: a write of 3 is legal; a write of 0 is legal only if U_MODE; any other value retains the previous value.
  - Writing minhv = 1 does not change the FSM.
- Same-cycle priority: trap_valid > mret_valid > csr_wen. The losing updates are dropped, except that ret_valid still pulses if mret coincides with csr_wen.
- Reset asserted mid-VEC_FETCH: FSM -> IDLE, all outputs return to reset values on that edge.

Decomposition:
- Shared package mcause_pkg:
  - Field bit-position localparams.
  - Privilege constants PRV_U = 0, PRV_M = 3.
  - Packed struct mcause_t.
  - FSM enum {IDLE, VEC_FETCH}.
  - pack/unpack functions.
- No sub-module needed; the WARL/pack logic stays inline.

Test Plan:
- Reset -> csr_rdata = 0x0000_0000 (U_MODE = 1); vec_busy = 0.
- Non-vectored trap: trap_irq = 0, code = 2, cur_priv = 0, cur_mie = 1, cur_il = 0x05 -> next cycle csr_rdata = 0x0805_0002; minhv = 0.
- Vectored irq: code = 11, shv = 1, priv = 3, mie = 0, il = 0 -> csr_rdata = 0xF000_000B and vec_busy = 1. vec_fetch_done 3 cycles later -> csr_rdata = 0xB000_000B, vec_busy = 0.
- Fault during VEC_FETCH: trap_valid with code = 5, irq = 0 -> csr_rdata = 0x7000_0005 (minhv retained), FSM -> IDLE.
- mret after the non-vectored trap -> ret_valid pulses 1 cycle later with ret_priv = 0, ret_mie = 1, ret_il = 0x05; afterwards mpp = 0, mpie = 1.
- CSR write 0x1000_0000 (mpp = 1) -> mpp unchanged. Write 0x3000_0000 -> mpp = 3. trap_valid + csr_wen in the same cycle -> trap values win.

Source files
------------

// File: rtl/mcause_trap_capture_pkg.sv
// Shared mcause layout: field positions, privilege encodings, the packed CSR view,
// the vector-fetch state type and pack/unpack helpers.
package mcause_pkg;

    localparam int unsigned INTR_BIT     = 31;
    localparam int unsigned MINHV_BIT    = 30;
    localparam int unsigned MPP_LSB      = 28;
    localparam int unsigned MPIE_BIT     = 27;
    localparam int unsigned MPIL_LSB     = 16;
    localparam int unsigned CODE_LSB     = 0;
    localparam int unsigned MPIL_FIELD_W = 8;
    localparam int unsigned CODE_FIELD_W = 16;

    localparam logic [1:0] PRV_U = 2'd0;
    localparam logic [1:0] PRV_M = 2'd3;

    typedef struct packed {
        logic                    interrupt;
        logic                    minhv;
        logic [1:0]              mpp;
        logic                    mpie;
        logic [2:0]              rsvd;
        logic [MPIL_FIELD_W-1:0] mpil;
        logic [CODE_FIELD_W-1:0] code;
    } mcause_t;

    typedef enum logic {
        IDLE,
        VEC_FETCH
    } trap_state_e;

    // Reserved bits 26:24 never leave or enter the register image.
    function automatic logic [31:0] pack_mcause(input mcause_t c);
        logic [31:0] r;
        r                           = '0;
        r[INTR_BIT]                 = c.interrupt;
        r[MINHV_BIT]                = c.minhv;
        r[MPP_LSB +: 2]             = c.mpp;
        r[MPIE_BIT]                 = c.mpie;
        r[MPIL_LSB +: MPIL_FIELD_W] = c.mpil;
        r[CODE_LSB +: CODE_FIELD_W] = c.code;
        return r;
    endfunction

    function automatic mcause_t unpack_mcause(input logic [31:0] r);
        mcause_t c;
        c           = '0;
        c.interrupt = r[INTR_BIT];
        c.minhv     = r[MINHV_BIT];
        c.mpp       = r[MPP_LSB +: 2];
        c.mpie      = r[MPIE_BIT];
        c.mpil      = r[MPIL_LSB +: MPIL_FIELD_W];
        c.code      = r[CODE_LSB +: CODE_FIELD_W];
        return c;
    endfunction

endpackage

// File: rtl/mcause_trap_capture.sv
// Machine trap-cause register (CLIC mcause): trap capture, hardware-vector fetch
// tracking via minhv, mret restore strobe and WARL CSR access.
module mcause_trap_capture
    import mcause_pkg::*;
#(
    parameter int unsigned CODE_W = 10,
    parameter int unsigned IL_W   = 8,
    parameter int unsigned U_MODE = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              trap_valid,
    input  logic              trap_irq,
    input  logic [CODE_W-1:0] trap_code,
    input  logic              trap_shv,
    input  logic [1:0]        cur_priv,
    input  logic              cur_mie,
    input  logic [IL_W-1:0]   cur_il,
    input  logic              vec_fetch_done,
    input  logic              mret_valid,
    input  logic              csr_wen,
    input  logic [31:0]       csr_wdata,
    output logic [31:0]       csr_rdata,
    output logic              ret_valid,
    output logic [1:0]        ret_priv,
    output logic              ret_mie,
    output logic [IL_W-1:0]   ret_il,
    output logic [CODE_W-1:0] code,
    output logic [IL_W-1:0]   mpil,
    output logic              mpie,
    output logic [1:0]        mpp,
    output logic              minhv,
    output logic              mcause_interrupt,
    output logic              vec_busy
);

    localparam logic [1:0] MPP_RST = (U_MODE != 0) ? PRV_U : PRV_M;

    trap_state_e state;
    mcause_t     rd_fields;
    mcause_t     wr_fields;
    logic        wr_mpp_legal;
    logic        wr_unused;

    always_comb begin
        rd_fields                  = '0;
        rd_fields.interrupt        = mcause_interrupt;
        rd_fields.minhv            = minhv;
        rd_fields.mpp              = mpp;
        rd_fields.mpie             = mpie;
        rd_fields.mpil[IL_W-1:0]   = mpil;
        rd_fields.code[CODE_W-1:0] = code;
    end

    assign csr_rdata    = pack_mcause(rd_fields);
    assign wr_fields    = unpack_mcause(csr_wdata);
    assign wr_unused    = ^{wr_fields.rsvd, wr_fields.code, wr_fields.mpil};
    assign wr_mpp_legal = (wr_fields.mpp == PRV_M) || ((wr_fields.mpp == PRV_U) && (U_MODE != 0));
    assign vec_busy     = (state == VEC_FETCH);

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= IDLE;
            code             <= '0;
            mpil             <= '0;
            mpie             <= 1'b0;
            mpp              <= MPP_RST;
            minhv            <= 1'b0;
            mcause_interrupt <= 1'b0;
            ret_valid        <= 1'b0;
            ret_priv         <= '0;
            ret_mie          <= 1'b0;
            ret_il           <= '0;
        end else begin
            ret_valid <= 1'b0;
            if (trap_valid) begin
                code             <= trap_code;
                mcause_interrupt <= trap_irq;
                mpp              <= cur_priv;
                mpie             <= cur_mie;
                mpil             <= cur_il;
                if (trap_irq && trap_shv) begin
                    minhv <= 1'b1;
                    state <= VEC_FETCH;
                end else if (state == VEC_FETCH) begin
                    // fetch fault: minhv keeps its value so software can see the table access failed
                    state <= IDLE;
                end else begin
                    minhv <= 1'b0;
                end
            end else if (mret_valid) begin
                ret_valid <= 1'b1;
                ret_priv  <= mpp;
                ret_mie   <= mpie;
                ret_il    <= mpil;
                mpp       <= MPP_RST;
                mpie      <= 1'b1;
                if (state == VEC_FETCH) begin
                    state <= IDLE;
                    minhv <= 1'b0;
                end
            end else begin
                if (csr_wen) begin
                    code             <= wr_fields.code[CODE_W-1:0];
                    mcause_interrupt <= wr_fields.interrupt;
                    minhv            <= wr_fields.minhv;
                    mpie             <= wr_fields.mpie;
                    mpil             <= wr_fields.mpil[IL_W-1:0];
                    if (wr_mpp_legal) begin
                        mpp <= wr_fields.mpp;
                    end
                end
                // fetch completion overrides a coincident software write of minhv
                if ((state == VEC_FETCH) && vec_fetch_done) begin
                    state <= IDLE;
                    minhv <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_mcause_trap_capture.sv
// Directed bench: stimulus queues expected register images and restore strobes;
// a monitor compares them against the DUT one time unit after each rising edge.
module tb_mcause_trap_capture;

    logic        clock = 1'b0;
    logic        reset;
    logic        trap_valid;
    logic        trap_irq;
    logic [9:0]  trap_code;
    logic        trap_shv;
    logic [1:0]  cur_priv;
    logic        cur_mie;
    logic [7:0]  cur_il;
    logic        vec_fetch_done;
    logic        mret_valid;
    logic        csr_wen;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;
    logic        ret_valid;
    logic [1:0]  ret_priv;
    logic        ret_mie;
    logic [7:0]  ret_il;
    logic [9:0]  code;
    logic [7:0]  mpil;
    logic        mpie;
    logic [1:0]  mpp;
    logic        minhv;
    logic        mcause_interrupt;
    logic        vec_busy;

    mcause_trap_capture #(.CODE_W(10), .IL_W(8), .U_MODE(1)) dut (
        .clock(clock), .reset(reset),
        .trap_valid(trap_valid), .trap_irq(trap_irq), .trap_code(trap_code),
        .trap_shv(trap_shv), .cur_priv(cur_priv), .cur_mie(cur_mie), .cur_il(cur_il),
        .vec_fetch_done(vec_fetch_done), .mret_valid(mret_valid),
        .csr_wen(csr_wen), .csr_wdata(csr_wdata), .csr_rdata(csr_rdata),
        .ret_valid(ret_valid), .ret_priv(ret_priv), .ret_mie(ret_mie), .ret_il(ret_il),
        .code(code), .mpil(mpil), .mpie(mpie), .mpp(mpp), .minhv(minhv),
        .mcause_interrupt(mcause_interrupt), .vec_busy(vec_busy)
    );

    always #5 clock = ~clock;

    typedef struct {
        int unsigned cyc;
        string       name;
        logic [31:0] rdata;
        logic        busy;
    } st_exp_t;

    typedef struct {
        int unsigned cyc;
        logic [1:0]  priv;
        logic        mie;
        logic [7:0]  il;
    } ret_exp_t;

    st_exp_t     st_q[$];
    ret_exp_t    ret_q[$];
    int unsigned cyc   = 0;
    int unsigned total = 0;
    int unsigned bad   = 0;

    // Monitor: state images are due on a tagged cycle; restores are due whenever ret_valid shows.
    always begin
        @(posedge clock);
        #1;
        cyc++;
        while (st_q.size() > 0 && st_q[0].cyc <= cyc) begin
            st_exp_t e;
            e = st_q.pop_front();
            total++;
            if (e.cyc != cyc) begin
                bad++;
                $display("FAIL %s: check missed its cycle (due %0d, now %0d)", e.name, e.cyc, cyc);
            end else if (csr_rdata !== e.rdata || vec_busy !== e.busy) begin
                bad++;
                $display("FAIL %s: csr_rdata=%h vec_busy=%b, expected csr_rdata=%h vec_busy=%b",
                         e.name, csr_rdata, vec_busy, e.rdata, e.busy);
            end
            total++;
            if ({mcause_interrupt, minhv, mpp, mpie, mpil, code} !==
                {e.rdata[31], e.rdata[30], e.rdata[29:28], e.rdata[27], e.rdata[23:16], e.rdata[9:0]}) begin
                bad++;
                $display("FAIL %s_fields: int=%b minhv=%b mpp=%0d mpie=%b mpil=%h code=%h, expected image %h",
                         e.name, mcause_interrupt, minhv, mpp, mpie, mpil, code, e.rdata);
            end
        end
        if (ret_valid === 1'b1) begin
            total++;
            if (ret_q.size() == 0) begin
                bad++;
                $display("FAIL ret_unexpected: ret_valid=1 at cycle %0d, expected no restore", cyc);
            end else begin
                ret_exp_t r;
                r = ret_q.pop_front();
                if (r.cyc != cyc || ret_priv !== r.priv || ret_mie !== r.mie || ret_il !== r.il) begin
                    bad++;
                    $display("FAIL ret: cycle=%0d priv=%0d mie=%b il=%h, expected cycle=%0d priv=%0d mie=%b il=%h",
                             cyc, ret_priv, ret_mie, ret_il, r.cyc, r.priv, r.mie, r.il);
                end
            end
        end else if (ret_q.size() > 0 && ret_q[0].cyc <= cyc) begin
            total++;
            bad++;
            $display("FAIL ret_missing: ret_valid=0 at cycle %0d, expected restore pulse", cyc);
            void'(ret_q.pop_front());
        end
    end

    task automatic tick();
        @(negedge clock);
        reset          = 1'b0;
        trap_valid     = 1'b0;
        trap_irq       = 1'b0;
        trap_shv       = 1'b0;
        vec_fetch_done = 1'b0;
        mret_valid     = 1'b0;
        csr_wen        = 1'b0;
    endtask

    task automatic expect_state(input string name, input logic [31:0] rdata, input logic busy);
        st_exp_t e;
        e.cyc   = cyc + 1;
        e.name  = name;
        e.rdata = rdata;
        e.busy  = busy;
        st_q.push_back(e);
    endtask

    task automatic expect_ret(input logic [1:0] priv, input logic mie, input logic [7:0] il);
        ret_exp_t r;
        r.cyc  = cyc + 1;
        r.priv = priv;
        r.mie  = mie;
        r.il   = il;
        ret_q.push_back(r);
    endtask

    task automatic trap(input logic irq, input logic shv, input logic [9:0] c,
                        input logic [1:0] priv, input logic mie, input logic [7:0] il);
        trap_valid = 1'b1;
        trap_irq   = irq;
        trap_shv   = shv;
        trap_code  = c;
        cur_priv   = priv;
        cur_mie    = mie;
        cur_il     = il;
    endtask

    task automatic csr_write(input logic [31:0] d);
        csr_wen   = 1'b1;
        csr_wdata = d;
    endtask

    initial begin
        reset = 1'b1; trap_valid = 1'b0; trap_irq = 1'b0; trap_code = '0; trap_shv = 1'b0;
        cur_priv = '0; cur_mie = 1'b0; cur_il = '0; vec_fetch_done = 1'b0;
        mret_valid = 1'b0; csr_wen = 1'b0; csr_wdata = '0;
        @(negedge clock);
        expect_state("reset", 32'h0000_0000, 1'b0);
        @(negedge clock);
        reset = 1'b0;

        tick(); trap(1'b0, 1'b0, 10'd2, 2'd0, 1'b1, 8'h05);
        expect_state("trap_plain", 32'h0805_0002, 1'b0);
        tick(); mret_valid = 1'b1;
        expect_ret(2'd0, 1'b1, 8'h05);
        expect_state("mret_plain", 32'h0805_0002, 1'b0);

        tick(); csr_write(32'h1000_0000);
        expect_state("wr_mpp1_kept", 32'h0000_0000, 1'b0);
        tick(); csr_write(32'h3000_0000);
        expect_state("wr_mpp3", 32'h3000_0000, 1'b0);
        tick(); mret_valid = 1'b1;
        expect_ret(2'd3, 1'b0, 8'h00);
        expect_state("mret_restore", 32'h0800_0000, 1'b0);
        tick(); csr_write(32'hFFFF_FFFF);
        expect_state("wr_all_ones", 32'hF8FF_03FF, 1'b0);
        tick(); csr_write(32'h0000_0000);
        expect_state("wr_mpp0", 32'h0000_0000, 1'b0);

        tick(); trap(1'b1, 1'b1, 10'd11, 2'd3, 1'b0, 8'h00);
        expect_state("vec_trap", 32'hF000_000B, 1'b1);
        tick(); expect_state("vec_wait1", 32'hF000_000B, 1'b1);
        tick(); expect_state("vec_wait2", 32'hF000_000B, 1'b1);
        tick(); vec_fetch_done = 1'b1;
        expect_state("vec_done", 32'hB000_000B, 1'b0);

        tick(); trap(1'b1, 1'b1, 10'd11, 2'd3, 1'b0, 8'h00);
        expect_state("vec_trap2", 32'hF000_000B, 1'b1);
        tick(); trap(1'b0, 1'b0, 10'd5, 2'd3, 1'b0, 8'h00);
        expect_state("fetch_fault", 32'h7000_0005, 1'b0);
        tick(); vec_fetch_done = 1'b1;
        expect_state("done_in_idle", 32'h7000_0005, 1'b0);

        tick(); trap(1'b1, 1'b1, 10'd11, 2'd3, 1'b0, 8'h00);
        expect_state("vec_trap3", 32'hF000_000B, 1'b1);
        tick(); trap(1'b1, 1'b1, 10'd4, 2'd0, 1'b1, 8'h03);
        expect_state("vec_refault", 32'hC803_0004, 1'b1);
        tick(); mret_valid = 1'b1;
        expect_ret(2'd0, 1'b1, 8'h03);
        expect_state("mret_abort", 32'h8803_0004, 1'b0);

        tick(); trap(1'b0, 1'b0, 10'd7, 2'd0, 1'b0, 8'h12); csr_write(32'hFFFF_FFFF);
        expect_state("trap_beats_csr", 32'h0012_0007, 1'b0);
        tick(); trap(1'b0, 1'b0, 10'd3, 2'd3, 1'b1, 8'h00); mret_valid = 1'b1;
        expect_state("trap_beats_mret", 32'h3800_0003, 1'b0);
        tick(); mret_valid = 1'b1; csr_write(32'hFFFF_FFFF);
        expect_ret(2'd3, 1'b1, 8'h00);
        expect_state("mret_beats_csr", 32'h0800_0003, 1'b0);

        tick(); trap(1'b1, 1'b1, 10'h3FF, 2'd3, 1'b1, 8'hFF);
        expect_state("vec_max", 32'hF8FF_03FF, 1'b1);
        tick(); reset = 1'b1;
        expect_state("reset_mid_fetch", 32'h0000_0000, 1'b0);

        tick(); tick(); tick();
        if (st_q.size() != 0 || ret_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: %0d state / %0d restore checks never reached, expected 0",
                     st_q.size(), ret_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

endmodule
